// File: rtl/modem_symbol_sched_if.sv
// Handshake and symbol bundle between a byte source and the modem symbol scheduler.
// The source drives mode_req/in_data/in_valid; the scheduler drives the rest.
interface modem_symbol_sched_if;
  logic [1:0] mode_req;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [3:0] sym;
  logic       sym_stb;
  logic       busy;

  modport master (
    output mode_req, in_data, in_valid,
    input  in_ready, mode, sym, sym_stb, busy
  );

  modport slave (
    input  mode_req, in_data, in_valid,
    output in_ready, mode, sym, sym_stb, busy
  );
endinterface

// File: rtl/modem_symbol_sched.sv
// Frames payload bytes into modem symbols: alternating preamble, MSB-first data symbols
// at 1/2/4 bits per symbol, one zero tail symbol, then a quiet tail period.
module modem_symbol_sched #(
  parameter int unsigned SPS           = 8,
  parameter int unsigned PREAMBLE_SYMS = 4
) (
  input logic                 clk,
  input logic                 rst,
  modem_symbol_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StTail} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pre_idx_q, pre_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bits_left_q, bits_left_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] sym_q, sym_d;

  logic       boundary, cnt_last, stb, ready;
  logic [3:0] bps, ones, sh_sym, in_sym;
  logic [7:0] sh_next, in_next;

  assign boundary = (cnt_q == 8'd0);
  assign cnt_last = (cnt_q == 8'(SPS - 1));

  // Per-mode symbol width, all-ones symbol and MSB-first slicing of shifter / incoming byte.
  always_comb begin
    case (mode_q)
      2'd1: begin
        bps     = 4'd2;
        ones    = 4'h3;
        sh_sym  = {2'b00, shreg_q[7:6]};
        sh_next = {shreg_q[5:0], 2'b00};
        in_sym  = {2'b00, bus.in_data[7:6]};
        in_next = {bus.in_data[5:0], 2'b00};
      end
      2'd2: begin
        bps     = 4'd4;
        ones    = 4'hF;
        sh_sym  = shreg_q[7:4];
        sh_next = {shreg_q[3:0], 4'h0};
        in_sym  = bus.in_data[7:4];
        in_next = {bus.in_data[3:0], 4'h0};
      end
      default: begin
        bps     = 4'd1;
        ones    = 4'h1;
        sh_sym  = {3'b000, shreg_q[7]};
        sh_next = {shreg_q[6:0], 1'b0};
        in_sym  = {3'b000, bus.in_data[7]};
        in_next = {bus.in_data[6:0], 1'b0};
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_idx_d   = pre_idx_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    mode_d      = mode_q;
    sym_d       = sym_q;
    stb         = 1'b0;
    ready       = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = cnt_last ? 8'd0 : cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        // Frame start only samples the byte's presence; the byte itself is taken in DATA.
        if (bus.in_valid) begin
          state_d     = StPreamble;
          cnt_d       = 8'd0;
          pre_idx_d   = 4'd0;
          bits_left_d = 4'd0;
          mode_d      = (bus.mode_req == 2'd3) ? 2'd0 : bus.mode_req;
        end
      end
      StPreamble: begin
        if (boundary) begin
          stb       = 1'b1;
          sym_d     = pre_idx_q[0] ? ones : 4'h0;
          pre_idx_d = pre_idx_q + 4'd1;
        end
        if (cnt_last && (pre_idx_q == 4'(PREAMBLE_SYMS))) begin
          state_d = StData;
        end
      end
      StData: begin
        ready = (bits_left_q == 4'd0);
        if (boundary) begin
          stb = 1'b1;
          if (bits_left_q != 4'd0) begin
            sym_d       = sh_sym;
            shreg_d     = sh_next;
            bits_left_d = bits_left_q - bps;
          end else if (bus.in_valid) begin
            sym_d       = in_sym;
            shreg_d     = in_next;
            bits_left_d = 4'd8 - bps;
          end else begin
            sym_d   = 4'h0;
            state_d = StTail;
          end
        end else if ((bits_left_q == 4'd0) && bus.in_valid) begin
          shreg_d     = bus.in_data;
          bits_left_d = 4'd8;
        end
      end
      StTail: begin
        // Leave on the wrap so the would-be boundary cycle is already IDLE.
        if (cnt_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      pre_idx_q   <= 4'd0;
      shreg_q     <= 8'd0;
      bits_left_q <= 4'd0;
      mode_q      <= 2'd0;
      sym_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_idx_q   <= pre_idx_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      mode_q      <= mode_d;
      sym_q       <= sym_d;
    end
  end

  assign bus.sym      = sym_d;
  assign bus.sym_stb  = stb;
  assign bus.in_ready = ready;
  assign bus.mode     = mode_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_modem_symbol_sched.sv
// Bench for modem_symbol_sched: directed frames plus randomized traffic, all checked against
// a frame/timing model built from symbol indices and a queue of pending data symbols.
module tb_modem_symbol_sched;
  localparam int SPS = 8;
  localparam int PRE = 4;

  logic clk = 1'b0;
  logic rst;
  modem_symbol_sched_if bus ();

  modem_symbol_sched #(.SPS(SPS), .PREAMBLE_SYMS(PRE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  bit m_act = 1'b0;
  int m_fs, m_mode = 0, m_last = 0, m_tail = -1;
  int pend[$];

  // Byte source
  logic [7:0] tx_q[$];
  int gap = 0, gap_max = 0, mreq = 0;

  // Observations for directed checks
  int seen[$];
  int n_stb, n_hs, hs_stb, last_stb_cyc, busy_fall_cyc, first_mode;
  bit prev_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void expand(input logic [7:0] d, input int bps, input int msk);
    for (int i = 0; i < 8 / bps; i++) pend.push_back((int'(d) >> (8 - bps * (i + 1))) & msk);
  endfunction

  task automatic reset_obs();
    seen.delete();
    n_stb = 0; n_hs = 0; hs_stb = -1; last_stb_cyc = -1; busy_fall_cyc = -1; first_mode = -1;
  endtask

  task automatic step(input bit r, input bit chk);
    bit v, bnd, acc;
    logic [7:0] d;
    int ph, idx, bps, msk;
    int e_busy, e_stb, e_rdy, e_sym, e_mode;
    v = (tx_q.size() > 0) && (gap == 0);
    d = v ? tx_q[0] : 8'h00;
    rst = r;
    bus.in_valid = v;
    bus.in_data = d;
    bus.mode_req = mreq[1:0];
    #1;
    e_busy = 0; e_stb = 0; e_rdy = 0; e_sym = m_last; e_mode = m_mode; acc = 1'b0; ph = 0;
    bps = 1 << m_mode;
    msk = (1 << bps) - 1;
    if (m_act) begin
      ph = cyc - m_fs - 1;
      idx = ph / SPS;
      bnd = (ph % SPS) == 0;
      e_busy = 1;
      if (m_tail < 0 && idx >= PRE && pend.size() == 0) e_rdy = 1;
      if (bnd && m_tail < 0) begin
        e_stb = 1;
        if (idx < PRE) e_sym = (idx % 2 == 1) ? msk : 0;
        else if (pend.size() > 0) e_sym = pend.pop_front();
        else if (v) begin acc = 1'b1; expand(d, bps, msk); e_sym = pend.pop_front(); end
        else begin e_sym = 0; m_tail = idx; end
      end else if (e_rdy == 1 && v) begin
        acc = 1'b1;
        expand(d, bps, msk);
      end
    end
    if (chk) begin
      check_eq("busy", 32'(bus.busy), e_busy);
      check_eq("sym_stb", 32'(bus.sym_stb), e_stb);
      check_eq("in_ready", 32'(bus.in_ready), e_rdy);
      check_eq("sym", 32'(bus.sym), e_sym);
      check_eq("mode", 32'(bus.mode), e_mode);
    end
    if (bus.sym_stb === 1'b1) begin
      if (n_stb == 0) first_mode = int'(bus.mode);
      seen.push_back(int'(bus.sym));
      n_stb++;
      last_stb_cyc = cyc;
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin n_hs++; hs_stb = n_stb; end
    if (prev_busy && bus.busy === 1'b0 && busy_fall_cyc < 0) busy_fall_cyc = cyc;
    prev_busy = (bus.busy === 1'b1);
    // Source side: a consumed byte leaves the queue, then an optional idle gap follows.
    if (acc) begin
      void'(tx_q.pop_front());
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    end else if (!v && gap > 0) gap--;
    if (r) begin
      m_act = 1'b0; m_mode = 0; m_last = 0; m_tail = -1; pend.delete();
    end else if (m_act) begin
      m_last = e_sym;
      if (m_tail >= 0 && ph == (m_tail + 1) * SPS - 1) m_act = 1'b0;
    end else if (v) begin
      m_act = 1'b1; m_fs = cyc; m_mode = (mreq == 3) ? 0 : mreq; m_tail = -1; pend.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic drain(input int max, input bit jitter);
    for (int i = 0; i < max && (m_act || tx_q.size() > 0); i++) begin
      if (jitter && $urandom_range(0, 15) == 0) mreq = $urandom_range(0, 3);
      step(1'b0, 1'b1);
    end
    check_eq("drain", 32'(tx_q.size()) + 32'(m_act), 0);
    run(3);
  endtask

  task automatic check_seen(input string tag, input int exp[9], input int n);
    for (int i = 0; i < n; i++) check_eq(tag, (i < seen.size()) ? seen[i] : -1, exp[i]);
  endtask

  int exp_s[9];

  initial begin
    // Reset held two cycles with a byte offered and mode_req=2
    mreq = 2;
    tx_q.push_back(8'h55);
    step(1'b1, 1'b0);
    reset_obs();
    step(1'b1, 1'b1);
    check_eq("rst_no_hs", n_hs, 0);
    tx_q.delete();
    run(3);

    // Mode 1, single byte 0xB4
    reset_obs(); mreq = 1; gap_max = 0; gap = 0;
    tx_q.push_back(8'hB4);
    drain(300, 1'b0);
    exp_s = '{0, 3, 0, 3, 2, 3, 1, 0, 0};
    check_eq("b4_nstb", n_stb, 9);
    check_seen("b4_sym", exp_s, 9);
    check_eq("b4_nhs", n_hs, 1);
    check_eq("b4_hs_at", hs_stb, 5);
    check_eq("b4_busy_fall", busy_fall_cyc - last_stb_cyc, 8);

    // Mode 2, back-to-back 0xA5, 0x3C
    reset_obs(); mreq = 2;
    tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
    drain(300, 1'b0);
    exp_s = '{0, 15, 0, 15, 10, 5, 3, 12, 0};
    check_eq("a5_nstb", n_stb, 9);
    check_seen("a5_sym", exp_s, 9);
    check_eq("a5_nhs", n_hs, 2);

    // Mode 0 frame with mode_req switched to 2 mid-DATA
    reset_obs(); mreq = 0;
    tx_q.push_back(8'h96); tx_q.push_back(8'h5A);
    run(PRE * SPS + 3 * SPS);
    mreq = 2;
    drain(400, 1'b0);
    check_eq("m0_nstb", n_stb, PRE + 16 + 1);
    check_eq("m0_mode", first_mode, 0);
    reset_obs();
    tx_q.push_back(8'h0F);
    drain(300, 1'b0);
    check_eq("m2_next_mode", first_mode, 2);
    check_eq("m2_next_nstb", n_stb, PRE + 2 + 1);

    // Reserved mode coerced to 0
    reset_obs(); mreq = 3;
    tx_q.push_back(8'hC3);
    drain(400, 1'b0);
    exp_s = '{0, 1, 0, 1, 1, 1, 0, 0, 0};
    check_seen("m3_sym", exp_s, 8);
    check_eq("m3_mode", first_mode, 0);

    // Reset mid-DATA discards the frame
    reset_obs(); mreq = 1;
    tx_q.push_back(8'hF0); tx_q.push_back(8'h0F);
    run(PRE * SPS + 12);
    step(1'b1, 1'b1);
    tx_q.delete();
    reset_obs();
    run(40);
    check_eq("rst_mid_nstb", n_stb, 0);
    check_eq("rst_mid_busy", 32'(bus.busy), 0);
    tx_q.push_back(8'h81);
    drain(300, 1'b0);

    // Randomized traffic: mixed modes, gaps that split frames, mode_req jitter
    for (int f = 0; f < 25; f++) begin
      mreq = $urandom_range(0, 3);
      gap_max = ($urandom_range(0, 1) == 1) ? 2 * SPS + 4 : 0;
      gap = 0;
      for (int b = 0, nb = $urandom_range(1, 4); b < nb; b++) tx_q.push_back(8'($urandom));
      drain(2000, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
